// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types, constants and byte/word helpers.
package aes_pkg;

  localparam int unsigned KEY_W      = 128;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned CNT_W      = 4;

  typedef logic [KEY_W-1:0]  key_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GEN,
    ST_DONE
  } ks_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

// File: rtl/aes128_key_schedule_if.sv
// Key-load request and round-key result bundle between key loader and round pipeline.
interface aes128_key_schedule_if;
  import aes_pkg::*;

  logic begin_key_gen_i;
  key_t initial_key;
  key_t round_keys      [NUM_ROUNDS];
  logic round_keys_done [NUM_ROUNDS];

  modport master (
    output begin_key_gen_i,
    output initial_key,
    input  round_keys,
    input  round_keys_done
  );

  modport slave (
    input  begin_key_gen_i,
    input  initial_key,
    output round_keys,
    output round_keys_done
  );

endinterface

// File: rtl/aes_key_round.sv
// One AES-128 key-expansion step: previous round key + rcon -> next round key.
module aes_key_round
  import aes_pkg::*;
(
  input  key_t       key_i,
  input  logic [7:0] rcon_i,
  output key_t       key_o
);

  word_t w0, w1, w2, w3;
  word_t t, n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_i;

  assign t  = sub_word(rot_word(w3)) ^ {rcon_i, 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_key_schedule.sv
// Iterative AES-128 key expansion: one round key per clock, each with its own ready flag.
module aes128_key_schedule
  import aes_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  aes128_key_schedule_if.slave  ks
);

  ks_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  key_t             work_q;
  key_t             next_key;
  logic [7:0]       rcon_c;
  logic             load_c;
  logic             gen_c;

  key_t keys_q [NUM_ROUNDS];
  logic done_q [NUM_ROUNDS];

  // Counter only sits in 1..10 while generating; idle values select no rcon.
  always_comb begin
    rcon_c = 8'h00;
    if (cnt_q != '0 && cnt_q <= CNT_W'(NUM_ROUNDS)) begin
      rcon_c = RCON[cnt_q];
    end
  end

  aes_key_round u_round (
    .key_i  (work_q),
    .rcon_i (rcon_c),
    .key_o  (next_key)
  );

  // Next-state: load dominates, so a mid-run request aborts and restarts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_c  = 1'b0;
    gen_c   = 1'b0;
    if (ks.begin_key_gen_i) begin
      state_d = ST_LOAD;
      cnt_d   = CNT_W'(1);
      load_c  = 1'b1;
    end else begin
      case (state_q)
        ST_LOAD, ST_GEN: begin
          gen_c   = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_q == CNT_W'(NUM_ROUNDS)) ? ST_DONE : ST_GEN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_c) begin
        work_q <= ks.initial_key;
      end else if (gen_c) begin
        work_q <= next_key;
      end
    end
  end

  // Round-key store: slot cnt-1 is written as the counter sweeps through it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_ROUNDS; i++) begin
        keys_q[i] <= '0;
        done_q[i] <= 1'b0;
      end
    end else if (load_c) begin
      for (int i = 0; i < NUM_ROUNDS; i++) begin
        done_q[i] <= 1'b0;
      end
    end else if (gen_c) begin
      for (int i = 0; i < NUM_ROUNDS; i++) begin
        if (cnt_q == CNT_W'(i + 1)) begin
          keys_q[i] <= next_key;
          done_q[i] <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_ROUNDS; g++) begin : g_out
    assign ks.round_keys[g]      = keys_q[g];
    assign ks.round_keys_done[g] = done_q[g];
  end

endmodule

// File: tb/tb_aes128_key_schedule.sv
// Self-checking bench for aes128_key_schedule against a GF(2^8)-derived key-expansion model.
module tb_aes128_key_schedule;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] mdl_rk [10];
  logic [9:0]   done_vec;

  typedef struct {
    string        name;
    logic [127:0] key;
    int           idx;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [7];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

  aes128_key_schedule_if ifc ();

  aes128_key_schedule dut (
    .clk_i (clk),
    .rst_i (rst),
    .ks    (ifc)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 10; i++) done_vec[i] = ifc.round_keys_done[i];
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]], sbox_m[t[31:24]]} ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 1; r <= 10; r++) mdl_rk[r-1] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load a key for one edge, then release and run 'edges' edges with junk on initial_key.
  task automatic run_key(input logic [127:0] key, input int edges);
    ifc.begin_key_gen_i = 1'b1;
    ifc.initial_key     = key;
    step();
    ifc.begin_key_gen_i = 1'b0;
    for (int e = 0; e < edges; e++) begin
      ifc.initial_key = rand128();
      step();
    end
  endtask

  task automatic chk_keys_zero(input string name);
    for (int i = 0; i < 10; i++) chk(name, ifc.round_keys[i], 128'h0);
  endtask

  task automatic chk_keys_model(input string name);
    for (int i = 0; i < 10; i++) chk(name, ifc.round_keys[i], mdl_rk[i]);
  endtask

  initial begin
    vecs[0] = '{"fips_rk0",  FIPS_KEY, 0, 128'ha0fafe1788542cb123a339392a6c7605};
    vecs[1] = '{"fips_rk1",  FIPS_KEY, 1, 128'hf2c295f27a96b9435935807a7359f67f};
    vecs[2] = '{"fips_rk2",  FIPS_KEY, 2, 128'h3d80477d4716fe3e1e237e446d7a883b};
    vecs[3] = '{"fips_rk9",  FIPS_KEY, 9, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[4] = '{"zero_rk0",  128'h0,   0, 128'h62636363626363636263636362636363};
    vecs[5] = '{"seq_rk0",   SEQ_KEY,  0, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
    vecs[6] = '{"seq_rk9",   SEQ_KEY,  9, 128'h13111d7fe3944a17f307a78b4d2b30c5};

    rst                 = 1'b1;
    ifc.begin_key_gen_i = 1'b0;
    ifc.initial_key     = '0;
    build_sbox();

    // Reset values, then idle with no load request.
    #12;
    chk("reset_flags", 128'(done_vec), 128'h0);
    chk_keys_zero("reset_keys");
    rst = 1'b0;
    repeat (3) step();
    chk("idle_flags", 128'(done_vec), 128'h0);

    // Holding the load request writes nothing, whatever the key does.
    ifc.begin_key_gen_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      ifc.initial_key = rand128();
      step();
      chk("hold_load_flags", 128'(done_vec), 128'h0);
    end
    chk_keys_zero("hold_load_keys");

    // Flag timing on the FIPS-197 key.
    model_expand(FIPS_KEY);
    run_key(FIPS_KEY, 0);
    for (int e = 1; e <= 10; e++) begin
      ifc.initial_key = rand128();
      step();
      chk("flag_edge", 128'(done_vec), 128'((1 << e) - 1));
    end
    chk_keys_model("fips_model");
    for (int c = 0; c < 20; c++) begin
      step();
      chk("done_hold_flags", 128'(done_vec), 128'h3ff);
      chk("done_hold_rk0", ifc.round_keys[0], mdl_rk[0]);
      chk("done_hold_rk9", ifc.round_keys[9], mdl_rk[9]);
    end

    // Known-answer table.
    foreach (vecs[v]) begin
      run_key(vecs[v].key, 10);
      chk(vecs[v].name, ifc.round_keys[vecs[v].idx], vecs[v].exp);
      chk({vecs[v].name, "_flags"}, 128'(done_vec), 128'h3ff);
    end

    // Restart mid-generation: flags clear, old keys kept until overwritten.
    model_expand(FIPS_KEY);
    run_key(FIPS_KEY, 5);
    chk("pre_restart_flags", 128'(done_vec), 128'h01f);
    ifc.begin_key_gen_i = 1'b1;
    ifc.initial_key     = SEQ_KEY;
    step();
    chk("restart_flags", 128'(done_vec), 128'h0);
    chk("restart_rk0_kept", ifc.round_keys[0], mdl_rk[0]);
    ifc.begin_key_gen_i = 1'b0;
    for (int e = 0; e < 10; e++) begin
      ifc.initial_key = rand128();
      step();
    end
    chk("restart_rk0", ifc.round_keys[0], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    chk("restart_rk9", ifc.round_keys[9], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("restart_done", 128'(done_vec), 128'h3ff);

    // Asynchronous reset between edges, mid-generation.
    run_key(rand128(), 4);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_flags", 128'(done_vec), 128'h0);
    chk_keys_zero("async_rst_keys");
    #1;
    rst = 1'b0;
    step();
    chk("post_rst_idle", 128'(done_vec), 128'h0);

    // Random keys against the model.
    for (int n = 0; n < 20; n++) begin
      logic [127:0] k;
      k = rand128();
      model_expand(k);
      run_key(k, 10);
      chk_keys_model("rand_key");
      chk("rand_flags", 128'(done_vec), 128'h3ff);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
